// File: rtl/pipe_ctrl_unit.sv
// ID-stage MIPS control decode with registered ID/EX, EX/MEM and MEM/WB control pipelines,
// load-use stall, taken-branch flush, r0 write suppression and a multicycle mult/div hold.
module pipe_ctrl_unit #(
  parameter int MD_LATENCY = 4,
  parameter int ALUOP_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [5:0]         id_opcode,
  input  logic [5:0]         id_funct,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic [4:0]         id_rd,
  input  logic               ex_branch_taken,
  output logic               pc_hold,
  output logic               ifid_hold,
  output logic               ifid_flush,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic               ex_ext_op,
  output logic               ex_branch,
  output logic               ex_md_start,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_reg_write,
  output logic [4:0]         mem_wreg,
  output logic [4:0]         wb_wreg,
  output logic [1:0]         mem_mem_to_reg,
  output logic [1:0]         wb_mem_to_reg,
  output logic               wb_reg_write,
  output logic               md_busy
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1a;

  typedef struct packed {
    logic [ALUOP_W-1:0] aluOp;
    logic               aluSrc;
    logic               extOp;
    logic               branch;
    logic               mdStart;
    logic               memRead;
    logic               memWrite;
    logic               regWrite;
    logic [4:0]         wreg;
    logic [1:0]         memToReg;
  } IdExCtrl;

  typedef struct packed {
    logic       memRead;
    logic       memWrite;
    logic       regWrite;
    logic [4:0] wreg;
    logic [1:0] memToReg;
  } ExMemCtrl;

  typedef struct packed {
    logic       regWrite;
    logic [4:0] wreg;
    logic [1:0] memToReg;
  } MemWbCtrl;

  IdExCtrl  idCtrl;
  IdExCtrl  idEx;
  ExMemCtrl exMem;
  MemWbCtrl memWb;
  logic [3:0] mdCount;

  logic isRType, isJ, isJal, isBeq, isBne, isAddi, isAddiu, isSlti, isSltiu;
  logic isAndi, isOri, isLui, isLw, isSw, isJr, isJalr, isMd, usesRt;
  logic [4:0] destReg;
  logic mdBusy, loadUse, flush;

  assign isRType = (id_opcode == OP_RTYPE);
  assign isJ     = (id_opcode == OP_J);
  assign isJal   = (id_opcode == OP_JAL);
  assign isBeq   = (id_opcode == OP_BEQ);
  assign isBne   = (id_opcode == OP_BNE);
  assign isAddi  = (id_opcode == OP_ADDI);
  assign isAddiu = (id_opcode == OP_ADDIU);
  assign isSlti  = (id_opcode == OP_SLTI);
  assign isSltiu = (id_opcode == OP_SLTIU);
  assign isAndi  = (id_opcode == OP_ANDI);
  assign isOri   = (id_opcode == OP_ORI);
  assign isLui   = (id_opcode == OP_LUI);
  assign isLw    = (id_opcode == OP_LW);
  assign isSw    = (id_opcode == OP_SW);
  assign isJr    = isRType && (id_funct == FN_JR);
  assign isJalr  = isRType && (id_funct == FN_JALR);
  assign isMd    = isRType && ((id_funct == FN_MULT) || (id_funct == FN_DIV));

  // I-type results land in rt; jal links into r31
  assign usesRt  = isLw || isLui || isAddi || isAddiu || isAndi || isOri || isSlti || isSltiu;
  assign destReg = usesRt ? id_rt : (isJal ? 5'd31 : id_rd);

  always_comb begin
    idCtrl = '0;
    if (id_valid) begin
      case (id_opcode)
        OP_RTYPE:          idCtrl.aluOp[2:0] = 3'b010;
        OP_BEQ, OP_BNE:    idCtrl.aluOp[2:0] = 3'b001;
        OP_ANDI:           idCtrl.aluOp[2:0] = 3'b100;
        OP_ORI:            idCtrl.aluOp[2:0] = 3'b011;
        OP_SLTI, OP_SLTIU: idCtrl.aluOp[2:0] = 3'b101;
        default:           idCtrl.aluOp[2:0] = 3'b000;
      endcase
      idCtrl.aluOp[3] = id_opcode[0];
      idCtrl.aluSrc   = isLw || isSw || isLui || isAddi || isAddiu || isAndi || isOri
                        || isSlti || isSltiu;
      idCtrl.extOp    = !(isAndi || isOri);
      idCtrl.branch   = isBeq || isBne;
      idCtrl.mdStart  = isMd;
      idCtrl.memRead  = isLw;
      idCtrl.memWrite = isSw;
      idCtrl.regWrite = !(isSw || isBeq || isBne || isJ || isJr || isMd) && (destReg != 5'd0);
      idCtrl.wreg     = destReg;
      idCtrl.memToReg = isLw ? 2'b01 : ((isJal || isJalr) ? 2'b10 : 2'b00);
    end
  end

  assign mdBusy  = (mdCount != 4'd0);
  assign loadUse = id_valid && idEx.memRead && (idEx.wreg != 5'd0)
                   && ((idEx.wreg == id_rs) || (idEx.wreg == id_rt));
  assign flush   = rst_n && ex_branch_taken;

  // A taken branch lets the front end run to the target even while mult/div holds EX
  assign pc_hold    = !flush && (mdBusy || loadUse);
  assign ifid_hold  = pc_hold;
  assign ifid_flush = flush;
  assign md_busy    = mdBusy;

  // During a mult/div hold ID/EX keeps the op (minus its start pulse) and EX/MEM fills with bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idEx    <= '0;
      exMem   <= '0;
      memWb   <= '0;
      mdCount <= 4'd0;
    end else begin
      memWb.regWrite <= exMem.regWrite;
      memWb.wreg     <= exMem.wreg;
      memWb.memToReg <= exMem.memToReg;
      if (mdBusy) begin
        idEx.mdStart <= 1'b0;
        exMem        <= '0;
        mdCount      <= mdCount - 4'd1;
      end else begin
        exMem.memRead  <= idEx.memRead;
        exMem.memWrite <= idEx.memWrite;
        exMem.regWrite <= idEx.regWrite;
        exMem.wreg     <= idEx.wreg;
        exMem.memToReg <= idEx.memToReg;
        if (flush || loadUse) begin
          idEx <= '0;
        end else begin
          idEx <= idCtrl;
          if (idCtrl.mdStart) mdCount <= 4'(MD_LATENCY - 1);
        end
      end
    end
  end

  assign ex_alu_op      = idEx.aluOp;
  assign ex_alu_src     = idEx.aluSrc;
  assign ex_ext_op      = idEx.extOp;
  assign ex_branch      = idEx.branch;
  assign ex_md_start    = idEx.mdStart;
  assign mem_read       = exMem.memRead;
  assign mem_write      = exMem.memWrite;
  assign mem_reg_write  = exMem.regWrite;
  assign mem_wreg       = exMem.wreg;
  assign mem_mem_to_reg = exMem.memToReg;
  assign wb_reg_write   = memWb.regWrite;
  assign wb_wreg        = memWb.wreg;
  assign wb_mem_to_reg  = memWb.memToReg;

endmodule
